// File: rtl/sram_arbiter_pkg.sv
// Shared types and widths for the SRAM port arbiter.
// The arbiter FSM state is exported on arb_state so checkers can follow it.
package sram_arbiter_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_ARB_IDLE = 2'd0,
    S_ARB_OWN  = 2'd1,
    S_ARB_TURN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_arbiter_rr_picker.sv
// Combinational round-robin select: first requester strictly after last_owner,
// wrapping, with last_owner itself considered last.
module sram_arbiter_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
        winner_idx  = idx;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin owner of the single SRAM port: burst grants, one-cycle turnaround
// bubble on owner change, and read-data routing back to the issuing requester.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int MAX_BURST    = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic                           clock_50,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             we_n,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] address,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] write_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             read_valid,
  output logic [DATA_W-1:0]              read_data,
  output logic [ADDR_W-1:0]              SRAM_address,
  output logic [DATA_W-1:0]              SRAM_write_data,
  output logic                           SRAM_we_n,
  input  logic [DATA_W-1:0]              SRAM_read_data,
  output logic [1:0]                     arb_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  // Handshake: an access is accepted on every rising edge where
  // req[i] & grant[i]; grant is registered and never depends on req this cycle.

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] tag_q [READ_LATENCY+1];

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               access;
  logic               others_pending;

  sram_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  assign access         = |(req & grant_q);
  assign others_pending = |(req & ~grant_q);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    grant_d      = '0;
    case (state_q)
      S_ARB_IDLE, S_ARB_TURN: begin
        if (pick_valid) begin
          state_d = S_ARB_OWN;
          owner_d = pick_idx;
          cnt_d   = '0;
          grant_d = pick_onehot;
        end else begin
          state_d = S_ARB_IDLE;
        end
      end
      S_ARB_OWN: begin
        grant_d = grant_q;
        if (!req[owner_q]) begin
          state_d      = S_ARB_TURN;
          last_owner_d = owner_q;
          grant_d      = '0;
        end else if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
          // Burst limit only forces a handover when someone else is waiting.
          if (others_pending) begin
            state_d      = S_ARB_TURN;
            last_owner_d = owner_q;
            grant_d      = '0;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q         <= S_ARB_IDLE;
      owner_q         <= '0;
      last_owner_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q           <= '0;
      grant_q         <= '0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      for (int i = 0; i <= READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      if (access) begin
        SRAM_address    <= address[owner_q];
        SRAM_write_data <= write_data[owner_q];
        SRAM_we_n       <= we_n[owner_q];
      end else begin
        SRAM_we_n <= 1'b1;
      end
      // Tag follows the read from address phase to data phase, independent of
      // whether the requester is still granted when the data comes back.
      tag_q[0] <= (access && we_n[owner_q]) ? grant_q : '0;
      for (int i = 1; i <= READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign grant      = grant_q;
  assign read_valid = tag_q[READ_LATENCY];
  assign read_data  = SRAM_read_data;
  assign arb_state  = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a 2-cycle SRAM model whose word at
// address a reads back as a[15:0] ^ 16'h5A5A.
module tb_sram_arbiter;

  logic              clock_50;
  logic              reset;
  logic [2:0]        req;
  logic [2:0]        we_n;
  logic [2:0][17:0]  address;
  logic [2:0][15:0]  write_data;
  logic [2:0]        grant;
  logic [2:0]        read_valid;
  logic [15:0]       read_data;
  logic [17:0]       SRAM_address;
  logic [15:0]       SRAM_write_data;
  logic              SRAM_we_n;
  logic [15:0]       SRAM_read_data;
  logic [1:0]        arb_state;

  int n_cmp;
  int n_err;

  logic [15:0] pipe0, pipe1;

  sram_arbiter dut (
    .clock_50        (clock_50),
    .reset           (reset),
    .req             (req),
    .we_n            (we_n),
    .address         (address),
    .write_data      (write_data),
    .grant           (grant),
    .read_valid      (read_valid),
    .read_data       (read_data),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .SRAM_read_data  (SRAM_read_data),
    .arb_state       (arb_state)
  );

  // clock/reset block
  initial clock_50 = 1'b0;
  always #10 clock_50 = ~clock_50;

  function automatic logic [15:0] mem_word(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  always @(posedge clock_50) begin
    pipe0 <= mem_word(SRAM_address);
    pipe1 <= pipe0;
  end
  assign SRAM_read_data = pipe1;

  task automatic idle_inputs();
    req        = '0;
    we_n       = '1;
    address    = '0;
    write_data = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clock_50);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clock_50);
    n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL reset_grant got %b expected 000", grant); end
    n_cmp++; if (read_valid !== 3'b000) begin n_err++; $display("FAIL reset_read_valid got %b expected 000", read_valid); end
    n_cmp++; if (SRAM_we_n !== 1'b1) begin n_err++; $display("FAIL reset_we_n got %b expected 1", SRAM_we_n); end
    n_cmp++; if (SRAM_address !== 18'd0) begin n_err++; $display("FAIL reset_address got %h expected 0", SRAM_address); end
    n_cmp++; if (SRAM_write_data !== 16'd0) begin n_err++; $display("FAIL reset_write_data got %h expected 0", SRAM_write_data); end
    n_cmp++; if (arb_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d expected 0", arb_state); end
  endtask

  // Requester 0 reads addresses 0..7 back to back.
  task automatic test_single_reads();
    logic [2:0] exp_rv;
    @(posedge clock_50); #1;
    req[0] = 1'b1; we_n[0] = 1'b1; address[0] = 18'd0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clock_50); #1;
      if (c <= 8) address[0] = 18'(c - 1);
      if (c == 9) req[0] = 1'b0;
      @(negedge clock_50);
      if (c <= 8) begin
        n_cmp++; if (grant !== 3'b001) begin n_err++; $display("FAIL single_grant c=%0d got %b expected 001", c, grant); end
      end
      if (c >= 2 && c <= 9) begin
        n_cmp++; if (SRAM_address !== 18'(c - 2)) begin n_err++; $display("FAIL single_address c=%0d got %0d expected %0d", c, SRAM_address, c - 2); end
        n_cmp++; if (SRAM_we_n !== 1'b1) begin n_err++; $display("FAIL single_we_n c=%0d got %b expected 1", c, SRAM_we_n); end
      end
      exp_rv = (c >= 4 && c <= 11) ? 3'b001 : 3'b000;
      n_cmp++; if (read_valid !== exp_rv) begin n_err++; $display("FAIL single_read_valid c=%0d got %b expected %b", c, read_valid, exp_rv); end
      if (exp_rv != 3'b000) begin
        n_cmp++; if (read_data !== mem_word(18'(c - 4))) begin n_err++; $display("FAIL single_read_data c=%0d got %h expected %h", c, read_data, mem_word(18'(c - 4))); end
      end
    end
    idle_inputs();
    repeat (4) @(posedge clock_50);
  endtask

  // Requester 2 writes one word; no read return must appear.
  task automatic test_write();
    @(posedge clock_50); #1;
    req[2] = 1'b1; we_n[2] = 1'b0; address[2] = 18'd76800; write_data[2] = 16'hABCD;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clock_50); #1;
      if (c == 2) idle_inputs();
      @(negedge clock_50);
      if (c == 1) begin
        n_cmp++; if (grant !== 3'b100) begin n_err++; $display("FAIL write_grant got %b expected 100", grant); end
      end
      if (c == 2) begin
        n_cmp++; if (SRAM_we_n !== 1'b0) begin n_err++; $display("FAIL write_we_n got %b expected 0", SRAM_we_n); end
        n_cmp++; if (SRAM_address !== 18'd76800) begin n_err++; $display("FAIL write_address got %0d expected 76800", SRAM_address); end
        n_cmp++; if (SRAM_write_data !== 16'hABCD) begin n_err++; $display("FAIL write_data got %h expected abcd", SRAM_write_data); end
      end
      if (c == 3) begin
        n_cmp++; if (SRAM_we_n !== 1'b1) begin n_err++; $display("FAIL write_we_n_after got %b expected 1", SRAM_we_n); end
      end
      n_cmp++; if (read_valid !== 3'b000) begin n_err++; $display("FAIL write_read_valid c=%0d got %b expected 000", c, read_valid); end
    end
    repeat (4) @(posedge clock_50);
  endtask

  // Requesters 0 and 1 both hold req from reset: 64-cycle bursts with a bubble.
  task automatic test_back_to_back();
    logic [2:0] exp_g;
    apply_reset();
    req[0] = 1'b1; req[1] = 1'b1; address[0] = 18'd1000; address[1] = 18'd2000;
    for (int c = 1; c <= 132; c++) begin
      @(posedge clock_50); #1;
      @(negedge clock_50);
      if (c <= 64) exp_g = 3'b001;
      else if (c == 65 || c == 130) exp_g = 3'b000;
      else if (c <= 129) exp_g = 3'b010;
      else exp_g = 3'b001;
      n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL b2b_grant c=%0d got %b expected %b", c, grant, exp_g); end
      if (c == 65 || c == 130) begin
        n_cmp++; if (arb_state !== 2'd2) begin n_err++; $display("FAIL b2b_turn_state c=%0d got %0d expected 2", c, arb_state); end
        n_cmp++; if (SRAM_we_n !== 1'b1) begin n_err++; $display("FAIL b2b_turn_we_n c=%0d got %b expected 1", c, SRAM_we_n); end
      end
    end
    @(posedge clock_50); #1;
    idle_inputs();
    repeat (4) @(posedge clock_50);
  endtask

  // Requester 1 stops after 3 reads while 2 waits; reads still return to 1.
  task automatic test_drop_mid_own();
    logic [2:0] exp_g;
    logic [2:0] exp_rv;
    @(posedge clock_50); #1;
    req[1] = 1'b1; req[2] = 1'b1; address[1] = 18'd100; address[2] = 18'd500;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clock_50); #1;
      if (c <= 3) address[1] = 18'(100 + c - 1);
      if (c == 4) req[1] = 1'b0;
      if (c == 9) req[2] = 1'b0;
      @(negedge clock_50);
      if (c <= 4) exp_g = 3'b010;
      else if (c == 5) exp_g = 3'b000;
      else if (c <= 9) exp_g = 3'b100;
      else exp_g = 3'b000;
      if (c <= 8) begin
        n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL drop_grant c=%0d got %b expected %b", c, grant, exp_g); end
      end
      if (c == 5) begin
        n_cmp++; if (arb_state !== 2'd2) begin n_err++; $display("FAIL drop_turn_state got %0d expected 2", arb_state); end
      end
      if (c >= 4 && c <= 6) exp_rv = 3'b010;
      else if (c >= 9) exp_rv = 3'b100;
      else exp_rv = 3'b000;
      n_cmp++; if (read_valid !== exp_rv) begin n_err++; $display("FAIL drop_read_valid c=%0d got %b expected %b", c, read_valid, exp_rv); end
      if (exp_rv == 3'b010) begin
        n_cmp++; if (read_data !== mem_word(18'(100 + c - 4))) begin n_err++; $display("FAIL drop_read_data1 c=%0d got %h expected %h", c, read_data, mem_word(18'(100 + c - 4))); end
      end
      if (exp_rv == 3'b100) begin
        n_cmp++; if (read_data !== mem_word(18'd500)) begin n_err++; $display("FAIL drop_read_data2 c=%0d got %h expected %h", c, read_data, mem_word(18'd500)); end
      end
    end
    idle_inputs();
    repeat (4) @(posedge clock_50);
  endtask

  // Sole requester 0 for 200 cycles: counter wraps, grant never drops.
  task automatic test_sole_requester();
    int bad_grant;
    bad_grant = 0;
    @(posedge clock_50); #1;
    req[0] = 1'b1; address[0] = 18'd0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock_50); #1;
      address[0] = 18'(c - 1);
      @(negedge clock_50);
      n_cmp++; if (grant !== 3'b001 || arb_state !== 2'd1) begin
        n_err++; bad_grant++;
        if (bad_grant <= 5) $display("FAIL sole_grant c=%0d got %b/%0d expected 001/1", c, grant, arb_state);
      end
      if (c >= 2) begin
        n_cmp++; if (SRAM_address !== 18'(c - 2)) begin n_err++; $display("FAIL sole_address c=%0d got %0d expected %0d", c, SRAM_address, c - 2); end
      end
    end
    idle_inputs();
    repeat (4) @(posedge clock_50);
  endtask

  // Reset with two reads in flight; last_owner is 0 beforehand, so a post-reset
  // grant to 0 (not 1) shows last_owner was restored.
  task automatic test_reset_inflight();
    @(posedge clock_50); #1;
    req[0] = 1'b1; address[0] = 18'd10;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clock_50); #1;
      if (c == 2) address[0] = 18'd11;
      if (c == 3) begin req = '0; reset = 1'b1; end
      if (c == 4) begin reset = 1'b0; req[0] = 1'b1; req[1] = 1'b1; address[0] = 18'd20; end
      @(negedge clock_50);
      if (c == 4) begin
        n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL rst_if_grant got %b expected 000", grant); end
        n_cmp++; if (SRAM_we_n !== 1'b1) begin n_err++; $display("FAIL rst_if_we_n got %b expected 1", SRAM_we_n); end
        n_cmp++; if (SRAM_address !== 18'd0) begin n_err++; $display("FAIL rst_if_address got %0d expected 0", SRAM_address); end
        n_cmp++; if (SRAM_write_data !== 16'd0) begin n_err++; $display("FAIL rst_if_write_data got %h expected 0", SRAM_write_data); end
        n_cmp++; if (arb_state !== 2'd0) begin n_err++; $display("FAIL rst_if_state got %0d expected 0", arb_state); end
      end
      if (c == 5) begin
        n_cmp++; if (grant !== 3'b001) begin n_err++; $display("FAIL rst_if_first_grant got %b expected 001", grant); end
      end
      if (c >= 4) begin
        n_cmp++; if (read_valid !== 3'b000) begin n_err++; $display("FAIL rst_if_read_valid c=%0d got %b expected 000", c, read_valid); end
      end
    end
    idle_inputs();
    repeat (4) @(posedge clock_50);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_reads();
    test_write();
    test_back_to_back();
    test_drop_mid_own();
    test_sole_requester();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
